// File: rtl/bouncing_ball_pkg.sv
// Shared game package: coordinate widths, playfield defaults and FSM state codes.
// Imported by the ball interface, the collision block and the ball controller.
package bouncing_ball_pkg;

  localparam int COORD_W = 13;
  localparam int ARITH_W = 14;
  localparam int HITS_W  = 8;
  localparam int CNT_W   = 16;

  localparam int DEF_COLS = 640;
  localparam int DEF_ROWS = 480;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_PLAY  = 2'd2;
  localparam logic [1:0] ST_MISS  = 2'd3;

  typedef logic signed [ARITH_W-1:0] coord_s_t;

  function automatic coord_s_t to_s(input logic [COORD_W-1:0] v);
    return $signed({1'b0, v});
  endfunction

endpackage

// File: rtl/bouncing_ball_if.sv
// Frame/paddle inputs and ball status outputs of the bouncing ball block.
// master drives the frame and paddle signals; slave is the ball controller.
interface bouncing_ball_if;
  import bouncing_ball_pkg::*;

  logic               newFrame;
  logic               active;
  logic               serve;
  logic [COORD_W-1:0] pRow;
  logic [COORD_W-1:0] pCol;
  logic [COORD_W-1:0] pH;
  logic [COORD_W-1:0] pW;
  logic [COORD_W-1:0] bRow;
  logic [COORD_W-1:0] bCol;
  logic [COORD_W-1:0] bSize;
  logic [1:0]         state;
  logic               hit;
  logic               miss;
  logic [HITS_W-1:0]  hits;

  modport master (
    output newFrame, active, serve, pRow, pCol, pH, pW,
    input  bRow, bCol, bSize, state, hit, miss, hits
  );

  modport slave (
    input  newFrame, active, serve, pRow, pCol, pH, pW,
    output bRow, bCol, bSize, state, hit, miss, hits
  );

endinterface

// File: rtl/ball_collide.sv
// Combinational next-position logic for one PLAY frame: candidate move,
// left-wall miss, paddle overlap and wall clamping, in that priority order.
module ball_collide
  import bouncing_ball_pkg::*;
#(
  parameter int SIZE  = 10,
  parameter int COLS  = DEF_COLS,
  parameter int ROWS  = DEF_ROWS,
  parameter int SPEED = 2
) (
  input  logic [COORD_W-1:0] i_row,
  input  logic [COORD_W-1:0] i_col,
  input  coord_s_t           i_dx,
  input  coord_s_t           i_dy,
  input  logic [COORD_W-1:0] i_p_row,
  input  logic [COORD_W-1:0] i_p_col,
  input  logic [COORD_W-1:0] i_p_h,
  input  logic [COORD_W-1:0] i_p_w,
  output logic               o_miss,
  output logic               o_hit,
  output logic [COORD_W-1:0] o_row,
  output logic [COORD_W-1:0] o_col,
  output coord_s_t           o_dx,
  output coord_s_t           o_dy
);

  localparam coord_s_t           HALF_LO = coord_s_t'(SIZE >> 1);
  localparam coord_s_t           HALF_HI = coord_s_t'((SIZE - 1) >> 1);
  localparam coord_s_t           SPD     = coord_s_t'(SPEED);
  localparam coord_s_t           ROWS_S  = coord_s_t'(ROWS);
  localparam coord_s_t           COLS_S  = coord_s_t'(COLS);
  localparam logic [COORD_W-1:0] ROW_MIN = COORD_W'(SIZE >> 1);
  localparam logic [COORD_W-1:0] ROW_MAX = COORD_W'(ROWS - 1 - ((SIZE - 1) >> 1));
  localparam logic [COORD_W-1:0] COL_MAX = COORD_W'(COLS - 1 - ((SIZE - 1) >> 1));

  coord_s_t w_cand_row, w_cand_col;
  coord_s_t w_top, w_bot, w_left, w_right;
  coord_s_t w_p_top, w_p_bot, w_p_left, w_p_right;
  logic     w_overlap;

  assign w_cand_row = to_s(i_row) + i_dy;
  assign w_cand_col = to_s(i_col) + i_dx;

  assign w_top   = w_cand_row - HALF_LO;
  assign w_bot   = w_cand_row + HALF_HI;
  assign w_left  = w_cand_col - HALF_LO;
  assign w_right = w_cand_col + HALF_HI;

  // Paddle extents use the same asymmetric split as the ball for even sizes.
  assign w_p_top   = to_s(i_p_row) - (to_s(i_p_h) >>> 1);
  assign w_p_bot   = to_s(i_p_row) + ((to_s(i_p_h) - 14'sd1) >>> 1);
  assign w_p_left  = to_s(i_p_col) - (to_s(i_p_w) >>> 1);
  assign w_p_right = to_s(i_p_col) + ((to_s(i_p_w) - 14'sd1) >>> 1);

  assign w_overlap = (w_left <= w_p_right) && (w_right >= w_p_left) &&
                     (w_top  <= w_p_bot)   && (w_bot   >= w_p_top);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    o_miss = 1'b0;
    o_hit  = 1'b0;
    o_row  = i_row;
    o_col  = i_col;
    o_dx   = i_dx;
    o_dy   = i_dy;
    if (w_left < 0) begin
      o_miss = 1'b1;
    end else if (w_overlap) begin
      // Ball stays put on a paddle hit; only the vertical wall still reflects dy.
      o_hit = 1'b1;
      o_dx  = (i_col >= i_p_col) ? SPD : -SPD;
      if (w_top < 0)            o_dy = SPD;
      else if (w_bot >= ROWS_S) o_dy = -SPD;
    end else begin
      o_row = COORD_W'(w_cand_row);
      o_col = COORD_W'(w_cand_col);
      if (w_top < 0) begin
        o_row = ROW_MIN;
        o_dy  = SPD;
      end else if (w_bot >= ROWS_S) begin
        o_row = ROW_MAX;
        o_dy  = -SPD;
      end
      if (w_right >= COLS_S) begin
        o_col = COL_MAX;
        o_dx  = -SPD;
      end
    end
  end

endmodule

// File: rtl/bouncing_ball.sv
// Bouncing ball controller: IDLE/SERVE/PLAY/MISS state machine advancing one
// step per active frame pulse, with hit/miss pulses and a saturating hit count.
module bouncing_ball
  import bouncing_ball_pkg::*;
#(
  parameter int SIZE         = 10,
  parameter int COLS         = DEF_COLS,
  parameter int ROWS         = DEF_ROWS,
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60
) (
  input logic             clk,
  input logic             reset,
  bouncing_ball_if.slave  bus
);

  localparam logic [COORD_W-1:0] ROW_C   = COORD_W'(ROWS / 2);
  localparam logic [COORD_W-1:0] COL_C   = COORD_W'(COLS / 2);
  localparam coord_s_t           SPD     = coord_s_t'(SPEED);
  localparam logic [CNT_W-1:0]   CNT_END = CNT_W'(SERVE_FRAMES - 1);

  logic [1:0]         r_state;
  logic [COORD_W-1:0] r_row, r_col;
  coord_s_t           r_dx, r_dy;
  logic [CNT_W-1:0]   r_cnt;
  logic [HITS_W-1:0]  r_hits;
  logic               r_hit, r_miss;

  logic               w_step;
  logic               w_miss, w_hit;
  logic [COORD_W-1:0] w_row, w_col;
  coord_s_t           w_dx, w_dy;

  assign w_step = bus.newFrame & bus.active & ~reset;

  ball_collide #(
    .SIZE  (SIZE),
    .COLS  (COLS),
    .ROWS  (ROWS),
    .SPEED (SPEED)
  ) u_collide (
    .i_row   (r_row),
    .i_col   (r_col),
    .i_dx    (r_dx),
    .i_dy    (r_dy),
    .i_p_row (bus.pRow),
    .i_p_col (bus.pCol),
    .i_p_h   (bus.pH),
    .i_p_w   (bus.pW),
    .o_miss  (w_miss),
    .o_hit   (w_hit),
    .o_row   (w_row),
    .o_col   (w_col),
    .o_dx    (w_dx),
    .o_dy    (w_dy)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    if (reset) begin
      r_state <= ST_IDLE;
      r_row   <= ROW_C;
      r_col   <= COL_C;
      r_dx    <= SPD;
      r_dy    <= SPD;
      r_cnt   <= '0;
      r_hits  <= '0;
      r_hit   <= 1'b0;
      r_miss  <= 1'b0;
    end else begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      if (w_step) begin
        case (r_state)
          ST_IDLE: begin
            if (bus.serve) begin
              r_state <= ST_SERVE;
              r_hits  <= '0;
              r_cnt   <= '0;
            end
          end
          ST_SERVE: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_END) r_state <= ST_PLAY;
          end
          ST_PLAY: begin
            if (w_miss) begin
              r_state <= ST_MISS;
              r_miss  <= 1'b1;
            end else begin
              r_row <= w_row;
              r_col <= w_col;
              r_dx  <= w_dx;
              r_dy  <= w_dy;
              if (w_hit) begin
                r_hit <= 1'b1;
                if (r_hits != '1) r_hits <= r_hits + 1'b1;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_row   <= ROW_C;
            r_col   <= COL_C;
            r_dx    <= SPD;
          end
        endcase
      end
    end
  end

  assign bus.bRow  = r_row;
  assign bus.bCol  = r_col;
  assign bus.bSize = COORD_W'(SIZE);
  assign bus.state = r_state;
  assign bus.hit   = r_hit;
  assign bus.miss  = r_miss;
  assign bus.hits  = r_hits;

endmodule

// File: tb/tb_bouncing_ball.sv
// Bench for bouncing_ball: integer reference model checked every cycle, a
// directed trajectory with hand-computed positions, then random stimulus.
module tb_bouncing_ball;

  localparam int SIZE = 10;
  localparam int COLS = 640;
  localparam int ROWS = 480;
  localparam int SPD  = 2;
  localparam int SF   = 4;

  logic clk;
  logic reset;
  bouncing_ball_if bus();

  bouncing_ball #(
    .SIZE(SIZE), .COLS(COLS), .ROWS(ROWS), .SPEED(SPD), .SERVE_FRAMES(SF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  bit cmp_en  = 0;

  // Reference model: ball as plain integers, rules applied directly.
  int m_state, m_row, m_col, m_dx, m_dy, m_cnt, m_hits, m_hit, m_miss;

  function automatic int top_of(int r, int h);   return r - h / 2;       endfunction
  function automatic int bot_of(int r, int h);   return r + (h - 1) / 2; endfunction

  function automatic bit boxes_touch(int r0, int c0, int h0, int w0,
                                     int r1, int c1, int h1, int w1);
    return (top_of(c0, w0) <= bot_of(c1, w1)) && (bot_of(c0, w0) >= top_of(c1, w1)) &&
           (top_of(r0, h0) <= bot_of(r1, h1)) && (bot_of(r0, h0) >= top_of(r1, h1));
  endfunction

  always @(posedge clk) begin
    int cr, cc, pr, pc, ph, pw;
    if (reset) begin
      m_state = 0; m_row = ROWS / 2; m_col = COLS / 2;
      m_dx = SPD; m_dy = SPD; m_cnt = 0; m_hits = 0; m_hit = 0; m_miss = 0;
    end else begin
      m_hit = 0; m_miss = 0;
      if (bus.newFrame && bus.active) begin
        pr = int'(bus.pRow); pc = int'(bus.pCol); ph = int'(bus.pH); pw = int'(bus.pW);
        if (m_state == 0) begin
          if (bus.serve) begin m_state = 1; m_hits = 0; m_cnt = 0; end
        end else if (m_state == 1) begin
          if (m_cnt == SF - 1) m_state = 2;
          m_cnt = m_cnt + 1;
        end else if (m_state == 2) begin
          cr = m_row + m_dy;
          cc = m_col + m_dx;
          if (top_of(cc, SIZE) < 0) begin
            m_state = 3; m_miss = 1;
          end else if (boxes_touch(cr, cc, SIZE, SIZE, pr, pc, ph, pw)) begin
            m_hit = 1;
            if (m_hits < 255) m_hits++;
            m_dx = (m_col >= pc) ? SPD : -SPD;
            if (top_of(cr, SIZE) < 0) m_dy = SPD;
            else if (bot_of(cr, SIZE) >= ROWS) m_dy = -SPD;
          end else begin
            m_row = cr; m_col = cc;
            if (top_of(cr, SIZE) < 0) begin m_row = SIZE / 2; m_dy = SPD; end
            else if (bot_of(cr, SIZE) >= ROWS) begin m_row = ROWS - 1 - (SIZE - 1) / 2; m_dy = -SPD; end
            if (bot_of(cc, SIZE) >= COLS) begin m_col = COLS - 1 - (SIZE - 1) / 2; m_dx = -SPD; end
          end
        end else begin
          m_state = 0; m_row = ROWS / 2; m_col = COLS / 2; m_dx = SPD;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      n_total++;
      if (int'(bus.state) != m_state || int'(bus.bRow) != m_row || int'(bus.bCol) != m_col ||
          int'(bus.hits) != m_hits || int'(bus.hit) != m_hit || int'(bus.miss) != m_miss ||
          int'(bus.bSize) != SIZE) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t: dut st=%0d pos=(%0d,%0d) hits=%0d hit=%0d miss=%0d size=%0d | model st=%0d pos=(%0d,%0d) hits=%0d hit=%0d miss=%0d",
                 $time, bus.state, bus.bRow, bus.bCol, bus.hits, bus.hit, bus.miss, bus.bSize,
                 m_state, m_row, m_col, m_hits, m_hit, m_miss);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_pos(input string name, input int r, input int c);
    check({name, "_row"}, int'(bus.bRow), r);
    check({name, "_col"}, int'(bus.bCol), c);
  endtask

  task automatic tick(input logic nf, input logic act, input logic srv, input logic rst);
    @(negedge clk);
    bus.newFrame = nf; bus.active = act; bus.serve = srv; reset = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic paddle(input int r, input int c, input int h, input int w);
    bus.pRow = 13'(r); bus.pCol = 13'(c); bus.pH = 13'(h); bus.pW = 13'(w);
  endtask

  initial begin
    reset = 1'b1;
    bus.newFrame = 1'b0; bus.active = 1'b0; bus.serve = 1'b0;
    paddle(4000, 4000, 2, 2);
    tick(1, 1, 1, 1);
    tick(0, 1, 0, 1);
    cmp_en = 1;

    // Reset state and idle without serve
    tick(1, 1, 0, 0);
    check("reset_state", int'(bus.state), 0);
    check_pos("reset", 240, 320);
    check("reset_hits", int'(bus.hits), 0);
    check("reset_pulses", int'({bus.hit, bus.miss}), 0);

    // Serve sequence
    tick(1, 1, 1, 0);
    check("serve_state", int'(bus.state), 1);
    repeat (3) tick(1, 1, 0, 0);
    tick(0, 1, 1, 0);
    check("serve_hold", int'(bus.state), 1);
    check_pos("serve", 240, 320);
    tick(1, 1, 0, 0);
    check("play_state", int'(bus.state), 2);

    // Pause holds everything
    repeat (3) tick(1, 0, 1, 0);
    check("pause_state", int'(bus.state), 2);
    check_pos("pause", 240, 320);

    // Trajectory with wall clamps; serve ignored in PLAY
    tick(1, 1, 1, 0);
    check_pos("move1", 242, 322);
    check("serve_ignored", int'(bus.state), 2);
    repeat (117) tick(1, 1, 0, 0);
    check_pos("bottom_clamp", 475, 556);
    repeat (40) tick(1, 1, 0, 0);
    check_pos("right_clamp", 395, 635);
    repeat (196) tick(1, 1, 0, 0);
    check_pos("top_clamp", 5, 243);
    repeat (119) tick(1, 1, 0, 0);
    check_pos("near_left", 243, 5);
    tick(1, 1, 0, 0);
    check("miss_state", int'(bus.state), 3);
    check("miss_pulse", int'(bus.miss), 1);
    check_pos("miss_hold", 243, 5);
    tick(0, 1, 0, 0);
    check("miss_pulse_end", int'(bus.miss), 0);
    tick(1, 1, 0, 0);
    check("miss_to_idle", int'(bus.state), 0);
    check_pos("recenter", 240, 320);

    // Paddle hit from the right side of the ball flips dx negative
    tick(1, 1, 1, 0);
    repeat (4) tick(1, 1, 0, 0);
    check("play_again", int'(bus.state), 2);
    paddle(240, 330, 50, 40);
    tick(1, 1, 0, 0);
    check("hit_pulse", int'(bus.hit), 1);
    check("hit_count", int'(bus.hits), 1);
    check_pos("hit_hold", 240, 320);
    tick(0, 1, 0, 0);
    check("hit_pulse_end", int'(bus.hit), 0);
    paddle(4000, 4000, 2, 2);
    tick(1, 1, 0, 0);
    check_pos("after_hit", 242, 318);

    // Saturating hit counter
    paddle(242, 318, 100, 100);
    repeat (254) tick(1, 1, 0, 0);
    check("hits_255", int'(bus.hits), 255);
    tick(1, 1, 0, 0);
    check("hits_sat", int'(bus.hits), 255);
    check("hit_pulse_sat", int'(bus.hit), 1);

    // Reset mid-PLAY wins over a frame step
    paddle(4000, 4000, 2, 2);
    tick(1, 1, 0, 0);
    tick(1, 1, 0, 1);
    check("mid_reset_state", int'(bus.state), 0);
    check_pos("mid_reset", 240, 320);
    check("mid_reset_hits", int'(bus.hits), 0);

    // Random stimulus against the model
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        if ($urandom_range(0, 3) == 0) paddle(4000, 4000, 2, 2);
        else paddle($urandom_range(0, 479), $urandom_range(0, 639),
                    $urandom_range(1, 120), $urandom_range(1, 60));
      end
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1499) == 0));
    end

    @(negedge clk);
    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bouncing_ball.md
BOUNCING_BALL -- requirements
Module: bouncing_ball

Interface
REQ-001 SHALL have parameter SIZE, default 10: ball square side in pixels.
REQ-002 SHALL have parameter COLS, default 640: active columns.
REQ-003 SHALL have parameter ROWS, default 480: active rows.
REQ-004 SHALL have parameter SPEED, default 2: per-frame velocity magnitude per axis.
REQ-005 SHALL have parameter SERVE_FRAMES, default 60: frames spent in SERVE before PLAY.
REQ-006 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-008 SHALL have port newFrame  input  1: frame-boundary pulse; each high cycle is one frame step.
REQ-009 SHALL have port active  input  1: 0 freezes all state (pause).
REQ-010 SHALL have port serve  input  1: level, sampled on frame steps in IDLE.
REQ-011 SHALL have port pRow, pCol  input  13 each: paddle center.
REQ-012 SHALL have port pH, pW  input  13 each: paddle height and width.
REQ-013 SHALL have port bRow, bCol  output  13 each: registered ball center.
REQ-014 SHALL have port bSize  output  13: constant SIZE.
REQ-015 SHALL have port state  output  2: IDLE=0, SERVE=1, PLAY=2, MISS=3.
REQ-016 SHALL have port hit, miss  output  1 each: one-cycle pulses.
REQ-017 SHALL have port hits  output  8: paddle hits since last serve, saturating at 255.

Function
REQ-018 A frame step SHALL be any cycle with newFrame=1, active=1 and reset=0; all register updates except pulse clearing SHALL occur only on frame steps, with outputs valid the following cycle.
REQ-019 Box edges SHALL be: top = row-(h>>1), bottom = row+((h-1)>>1), left = col-(w>>1), right = col+((w-1)>>1), for both ball (h=w=SIZE) and paddle.
REQ-020 Edge and candidate arithmetic SHALL be 14-bit signed; velocities dx, dy SHALL be signed with values +SPEED or -SPEED only.
REQ-021 IDLE: ball held at (ROWS/2, COLS/2); on a frame step with serve=1, go to SERVE, clear hits, and load frame counter with 0.
REQ-022 SERVE: ball held; the counter increments each frame step; the step on which the counter equals SERVE_FRAMES-1 SHALL go to PLAY.
REQ-023 PLAY candidate: (bRow+dy, bCol+dx), evaluated per frame step in the fixed priority order given by REQ-024 to REQ-026.
REQ-024 Priority 1: candidate left edge < 0 -> go to MISS, pulse miss, ball position unchanged.
REQ-025 Priority 2: candidate box overlaps paddle box (inclusive edges) -> position unchanged; dx = +SPEED if bCol >= pCol else -SPEED; pulse hit; hits += 1 with saturation.
REQ-026 Priority 3: otherwise move to the candidate, clamped as follows: if top < 0, set row = SIZE>>1 and dy = +SPEED; if bottom >= ROWS, set row = ROWS-1-((SIZE-1)>>1) and dy = -SPEED; if right >= COLS, set col = COLS-1-((SIZE-1)>>1) and dx = -SPEED.
REQ-027 Under a REQ-025 paddle hit, REQ-026 vertical reflection of dy SHALL still apply; horizontal clamping SHALL not apply.
REQ-028 MISS: one frame step -> IDLE; ball re-centered; dx = +SPEED; dy retained.
REQ-029 hit and miss SHALL be high for exactly the cycle after the causing step and low otherwise.
REQ-030 With active=0, state, position, velocity, counter and hits SHALL hold, and no pulses SHALL be generated.
REQ-031 serve SHALL be ignored outside IDLE.

Reset
REQ-032 reset=1 SHALL, at the next edge and regardless of state or newFrame, set: state=IDLE, bRow=ROWS/2, bCol=COLS/2, dx=+SPEED, dy=+SPEED, counter=0, hits=0, hit=0, miss=0.
REQ-033 Reset SHALL take priority over every frame step, including a reset asserted mid-PLAY.

Structure
REQ-034 The state encodings and default COLS/ROWS SHALL reside in the shared game package.
REQ-035 The combinational candidate, edge, overlap and clamp logic SHALL be one sub-module, ball_collide; the state machine and registers SHALL be in bouncing_ball.

Verification (SIZE=10, SPEED=2, SERVE_FRAMES=4; paddle far away unless stated)
REQ-036 Reset, then serve=1 for one step -> state SERVE; after 4 further steps, state PLAY; ball at (240,320) throughout.
REQ-037 PLAY, ball at (6,100), dy=-2 -> next position (5,102) with dy=+2.
REQ-038 Ball at (240,30), dx=-2, paddle center (240,20), size 50x20 -> position unchanged, dx=+2, hit pulsed for 1 cycle, hits=1.
REQ-039 Ball at (240,6), dx=-2, no paddle -> miss pulse, state MISS, then IDLE at (240,320) on the next step.
REQ-040 active=0 with newFrame pulses in PLAY -> no change; reset asserted mid-PLAY -> IDLE at (240,320) the next cycle.
REQ-041 hits=255 plus one more hit -> hits stays 255 and hit still pulses.
